// File: rtl/uart_fifo_sched_if.sv
// rtl/uart_fifo_sched_if.sv - producer, FIFO and transmitter signals of uart_fifo_sched
interface uart_fifo_sched_if #(
  parameter int DATA_W = 8,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_data_in;
  logic              fifo_full;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_empty;
  logic              tx_en;
  logic [GAP_W-1:0]  gap_cfg;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  sent_count;
  logic              last_grant;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_full, fifo_data_out, fifo_empty, tx_en, gap_cfg, tx_busy,
    output req0_ready, req1_ready, fifo_wr, fifo_data_in, fifo_rd,
    output tx_start, tx_data, sent_count, last_grant
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_full, fifo_data_out, fifo_empty, tx_en, gap_cfg, tx_busy,
    input  req0_ready, req1_ready, fifo_wr, fifo_data_in, fifo_rd,
    input  tx_start, tx_data, sent_count, last_grant
  );
endinterface

// File: rtl/uart_fifo_sched.sv
// rtl/uart_fifo_sched.sv - round-robin FIFO writer and framed UART TX read scheduler
module uart_fifo_sched #(
  parameter int DATA_W = 8,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  uart_fifo_sched_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_next;
  logic [DATA_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_sent_count;
  logic              r_last_grant;
  logic              w_grant;
  logic              w_any_valid;
  logic              w_accept;
  logic              w_fifo_rd;
  logic              w_tx_start;

  // Contested cycles go to the producer that did not win the last accepted write.
  always_comb begin
    w_any_valid = bus.req0_valid || bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) w_grant = ~r_last_grant;
    else                                  w_grant = bus.req1_valid;
    w_accept = w_any_valid && !bus.fifo_full;
  end

  assign bus.req0_ready   = w_accept && !w_grant;
  assign bus.req1_ready   = w_accept && w_grant;
  assign bus.fifo_wr      = w_accept;
  assign bus.fifo_data_in = !w_any_valid ? '0 : (w_grant ? bus.req1_data : bus.req0_data);

  always_comb begin
    w_next     = r_state;
    w_gap_next = r_gap_cnt;
    w_fifo_rd  = 1'b0;
    w_tx_start = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.tx_en && !bus.fifo_empty && !bus.tx_busy) w_next = S_POP;
      S_POP: begin
        if (!bus.fifo_empty) begin
          w_fifo_rd = 1'b1;
          w_next    = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD:  w_next = S_START;
      S_START: begin
        w_tx_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (bus.gap_cfg == '0) begin
            w_next = S_IDLE;
          end else begin
            w_next     = S_GAP;
            w_gap_next = bus.gap_cfg;
          end
        end
      end
      S_GAP: begin
        w_gap_next = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt <= GAP_W'(1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Byte read in POP is presented by the FIFO one cycle later, during LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_tx_data    <= '0;
      r_sent_count <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= w_gap_next;
      if (r_state == S_LOAD) r_tx_data <= bus.fifo_data_out;
      if (w_tx_start) r_sent_count <= r_sent_count + CNT_W'(1);
      if (w_accept) r_last_grant <= w_grant;
    end
  end

  assign bus.fifo_rd    = w_fifo_rd;
  assign bus.tx_start   = w_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.sent_count = r_sent_count;
  assign bus.last_grant = r_last_grant;
endmodule
